// File: rtl/gray_bin_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides.
// Gray->binary prefix-XOR is split MSB-first into STAGES chunks, one chunk per stage.
module gray_bin_conv_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_mode_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_mode_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             busy_o
);

  localparam int C = (WIDTH + STAGES - 1) / STAGES;

  // Resolve chunk k in place; bits above it are already binary, so bit top+1
  // is the carry-in from the previous chunk. Chunk 0's MSB passes unchanged.
  function automatic logic [WIDTH-1:0] g2b_chunk(input logic [WIDTH-1:0] d, input int k);
    logic [WIDTH-1:0] r;
    r = d;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if ((i <= WIDTH - 1 - k * C) && (i >= WIDTH - (k + 1) * C))
        r[i] = r[i] ^ r[i+1];
    end
    return r;
  endfunction

  logic [STAGES-1:0]            r_vld;
  logic [STAGES-1:0]            r_mode;
  logic [STAGES-1:0][WIDTH-1:0] r_data;

  logic [STAGES-1:0]            w_adv;
  logic [STAGES-1:0]            w_vin;
  logic [STAGES-1:0]            w_min;
  logic [STAGES-1:0][WIDTH-1:0] w_nxt;
  logic                         w_carry;
  logic                         w_rdy;

  always_comb begin
    w_adv   = '0;
    w_vin   = '0;
    w_min   = '0;
    w_nxt   = '0;
    w_carry = out_ready_i;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_adv[s] = !r_vld[s] || w_carry;
      w_carry  = w_adv[s];
    end
    w_rdy    = w_adv[0] && !rst_i;
    w_vin[0] = in_valid_i && w_rdy;
    w_min[0] = in_mode_i;
    w_nxt[0] = in_mode_i ? g2b_chunk(in_data_i, 0) : (in_data_i ^ (in_data_i >> 1));
    for (int s = 1; s < STAGES; s++) begin
      w_vin[s] = r_vld[s-1];
      w_min[s] = r_mode[s-1];
      w_nxt[s] = r_mode[s-1] ? g2b_chunk(r_data[s-1], s) : r_data[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld  <= '0;
      r_mode <= '0;
      r_data <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_adv[s]) begin
          r_vld[s] <= w_vin[s];
          if (w_vin[s]) begin
            r_data[s] <= w_nxt[s];
            r_mode[s] <= w_min[s];
          end
        end
      end
    end
  end

  assign in_ready_o  = w_rdy;
  assign out_valid_o = r_vld[STAGES-1];
  assign out_mode_o  = r_mode[STAGES-1];
  assign out_data_o  = r_data[STAGES-1];
  assign busy_o      = |r_vld;

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Bench for gray_bin_conv_pipe: 8-bit/2-stage directed + stream tests and a
// parallel configuration sweep of round-trip conversions.
module tb_gray_bin_conv_pipe;

  localparam int NCFG = 10;

  function automatic int cfg_w(input int i);
    case (i)
      0:       return 1;
      1, 2, 3: return 5;
      4, 5, 6: return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      0: return 1;  1: return 1;  2: return 3;  3: return 5;
      4: return 1;  5: return 3;  6: return 32;
      7: return 1;  8: return 3;  default: return 64;
    endcase
  endfunction

  function automatic logic [63:0] m_mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] m_b2g(input logic [63:0] x, input int w);
    logic [63:0] v;
    v = x & m_mask(w);
    return (v ^ (v >> 1)) & m_mask(w);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [63:0] m_g2b(input logic [63:0] g, input int w);
    logic [63:0] b, v;
    v = g & m_mask(w);
    b = '0;
    for (int i = 0; i < w; i++) b = b ^ (v >> i);
    return b & m_mask(w);
  endfunction

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  logic clk = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main DUT: WIDTH=8, STAGES=2 ----------------
  logic       rst, iv, ir, im, ov, ordy, om, busy;
  logic [7:0] id, od;

  gray_bin_conv_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(ir), .in_mode_i(im),
    .in_data_i(id), .out_valid_o(ov), .out_ready_i(ordy), .out_mode_o(om),
    .out_data_o(od), .busy_o(busy)
  );

  typedef struct { logic [7:0] d; logic m; int acc; } beat_t;
  beat_t       exp_q[$];
  beat_t       cur;
  logic [63:0] tmp;
  logic        stall_pend = 0;
  logic [7:0]  s_d;
  logic        s_m;
  logic        lat_chk = 0;
  int          out_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_pend = 0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", ov, 1);
        chk("stall_data", od, s_d);
        chk("stall_mode", om, s_m);
      end
      if (ov && ordy) begin
        out_cnt++;
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          cur = exp_q.pop_front();
          chk("out_data", od, cur.d);
          chk("out_mode", om, cur.m);
          if (lat_chk) chk("latency", cyc + 1 - cur.acc, 2);
        end
      end
      stall_pend = ov && !ordy;
      s_d = od;
      s_m = om;
      if (iv && ir) begin
        tmp = im ? m_g2b(64'(id), 8) : m_b2g(64'(id), 8);
        cur.d = tmp[7:0];
        cur.m = im;
        cur.acc = cyc + 1;
        exp_q.push_back(cur);
      end
    end
  end

  task automatic direct(input logic [7:0] d, input logic m, input logic [7:0] e, input string nm);
    int n;
    n = 0;
    @(posedge clk); #1;
    iv = 1; id = d; im = m; ordy = 1;
    @(posedge clk); #1;
    iv = 0;
    while (!ov && n < 10) begin @(negedge clk); n++; end
    chk({nm, "_lat"}, n, 2);
    chk({nm, "_data"}, od, e);
    chk({nm, "_mode"}, om, m);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_qempty"}, exp_q.size(), 0);
  endtask

  logic [NCFG-1:0] done;
  logic            rnd_done;

  initial begin
    int base, n, guard;
    logic acc;
    rst = 1; iv = 0; im = 0; id = '0; ordy = 0; rnd_done = 0;

    chk("pin_b2g_B4", m_b2g(64'hB4, 8), 64'hEE);
    chk("pin_g2b_EE", m_g2b(64'hEE, 8), 64'hB4);
    chk("pin_g2b_80", m_g2b(64'h80, 8), 64'hFF);
    chk("pin_b2g_80", m_b2g(64'h80, 8), 64'hC0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ir, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_valid", ov, 0);
    chk("post_rst_data", od, 0);
    chk("post_rst_mode", om, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", ir, 1);

    lat_chk = 1;
    direct(8'hB4, 0, 8'hEE, "b2g_B4");
    direct(8'hEE, 1, 8'hB4, "g2b_EE");
    direct(8'h80, 1, 8'hFF, "g2b_80");
    direct(8'h80, 0, 8'hC0, "b2g_80");
    direct(8'h00, 0, 8'h00, "b2g_00");
    direct(8'h00, 1, 8'h00, "g2b_00");

    // back-to-back interleaved stream, full throughput
    base = out_cnt;
    for (int i = 0; i < 256; i++) begin
      iv = 1; id = 8'(i); im = i[0];
      @(posedge clk); #1;
    end
    iv = 0;
    drain("stream");
    chk("stream_count", out_cnt - base, 256);

    // random stream with random backpressure
    lat_chk = 0;
    base = out_cnt;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          if ($urandom_range(0, 3) == 0) begin iv = 0; @(posedge clk); #1; end
          iv = 1; id = 8'($urandom); im = 1'($urandom);
          guard = 0;
          do begin
            @(negedge clk); acc = ir;
            @(posedge clk); #1;
            guard++;
          end while (!acc && guard < 1000);
          if (!acc) chk("rand_accept_timeout", 0, 1);
        end
        iv = 0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ordy = 1'($urandom_range(0, 1));
        end
      end
    join
    ordy = 1;
    drain("rand");
    chk("rand_count", out_cnt - base, 1000);

    // fill pipe with backpressure, then reset mid-flight
    ordy = 0;
    iv = 1; id = 8'hA5; im = 0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("full_ready", ir, 0);
    chk("full_valid", ov, 1);
    chk("full_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1; iv = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_valid", ov, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", od, 0);
    chk("midrst_mode", om, 0);
    lat_chk = 1;
    direct(8'h3C, 0, 8'h22, "postrst_b2g");
    direct(8'h22, 1, 8'h3C, "postrst_g2b");

    n = 0;
    while (done !== {NCFG{1'b1}} && n < 40000) begin @(posedge clk); n++; end
    chk("sweep_done", 64'(done), 64'({NCFG{1'b1}}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- configuration sweep ----------------
  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int W = cfg_w(c);
    localparam int S = cfg_s(c);
    logic         rst_s, iv_s, ir_s, im_s, ov_s, om_s, bz_s, or_s;
    logic [W-1:0] id_s, od_s;
    logic [63:0]  eq_d[$];
    logic         eq_m[$];
    int           acc_q[$];
    logic [63:0]  mon_e;
    logic         mon_m;
    int           mon_a;

    gray_bin_conv_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk_i(clk), .rst_i(rst_s), .in_valid_i(iv_s), .in_ready_o(ir_s), .in_mode_i(im_s),
      .in_data_i(id_s), .out_valid_o(ov_s), .out_ready_i(or_s), .out_mode_o(om_s),
      .out_data_o(od_s), .busy_o(bz_s)
    );

    always @(negedge clk) begin
      if (!rst_s) begin
        if (ov_s) begin
          if (eq_d.size() == 0 || acc_q.size() == 0) chk($sformatf("sw%0d_spurious", c), 1, 0);
          else begin
            mon_e = eq_d.pop_front();
            mon_m = eq_m.pop_front();
            mon_a = acc_q.pop_front();
            chk($sformatf("sw%0d_data", c), 64'(od_s), mon_e);
            chk($sformatf("sw%0d_mode", c), om_s, mon_m);
            chk($sformatf("sw%0d_latency", c), cyc + 1 - mon_a, S);
          end
        end
        if (iv_s) begin
          chk($sformatf("sw%0d_ready", c), ir_s, 1);
          if (ir_s) acc_q.push_back(cyc + 1);
        end
      end
    end

    initial begin
      logic [63:0] x, g;
      int n;
      rst_s = 1; iv_s = 0; im_s = 0; id_s = '0; or_s = 1; done[c] = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_s = 0;
      n = (W <= 8) ? (1 << W) : 10000;
      for (int k = 0; k < n; k++) begin
        x = (W <= 8) ? 64'(k) : ({$urandom, $urandom} & m_mask(W));
        g = m_b2g(x, W);
        iv_s = 1; im_s = 0; id_s = x[W-1:0];
        eq_d.push_back(g); eq_m.push_back(0);
        @(posedge clk); #1;
        im_s = 1; id_s = g[W-1:0];
        eq_d.push_back(x); eq_m.push_back(1);
        @(posedge clk); #1;
      end
      iv_s = 0;
      repeat (S + 4) @(posedge clk);
      #1;
      chk($sformatf("sw%0d_drain", c), eq_d.size(), 0);
      chk($sformatf("sw%0d_busy", c), bz_s, 0);
      done[c] = 1;
    end
  end

endmodule

// File: doc/gray_bin_conv_pipe.md
Name: gray_bin_conv_pipe

Overview:
Parametrised, pipelined, bidirectional Gray/binary converter with a valid/ready stream interface on both sides. A per-beat mode bit selects binary->Gray or Gray->binary. The Gray->binary prefix-XOR chain is split across STAGES register stages so wide words meet timing. It sits between clock-domain-crossing pointer logic, counters and any consumer that needs a throttled, back-pressured conversion stream.

Parameters:
WIDTH, 32, data width in bits (>=1)
STAGES, 2, pipeline register stages (1..WIDTH); also the accept-to-output latency in cycles

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
in_valid_i  input  1  input beat valid
in_ready_o  output  1  block can accept a beat this cycle
in_mode_i  input  1  0 = binary->Gray, 1 = Gray->binary
in_data_i  input  WIDTH  word to convert
out_valid_o  output  1  output beat valid
out_ready_i  input  1  downstream accepts the beat this cycle
out_mode_o  output  1  mode of the beat on out_data_o
out_data_o  output  WIDTH  converted word
busy_o  output  1  at least one stage holds a valid beat

Behaviour:
- Reset (rst_i=1 at a rising edge): all stage valids, data and mode registers clear to 0.
- While rst_i=1: in_ready_o=0 and no beat is accepted. Cycle after reset deasserts: out_valid_o=0, out_data_o=0, out_mode_o=0, busy_o=0, in_ready_o=1.
- Transfer rules: input transfer when in_valid_i&&in_ready_o; output transfer when out_valid_o&&out_ready_i.
- Stage s advances when it is empty or stage s+1 advances. The last stage advances on out_ready_i or when empty. in_ready_o = stage 0 may advance (combinational from out_ready_i and the valid bits, not from in_valid_i).
- Bubbles collapse; sustained throughput is 1 beat/cycle when out_ready_i=1.
- Latency: a beat accepted at edge N is presented with out_valid_o=1 in the cycle after edge N+STAGES-1 (STAGES=1: the following cycle), absent stalls.
- Stall: while out_valid_o&&!out_ready_i, out_data_o and out_mode_o hold stable, and no beat is dropped or duplicated.
- Ordering: strictly FIFO. Mixed modes may be interleaved beat by beat. Mode travels with its data.
- Binary->Gray: g[W-1]=b[W-1]; g[i]=b[i+1]^b[i]. Computed entirely in stage 0; later stages pass it through.
- Gray->binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
  - Bits are partitioned MSB-first into STAGES chunks of C=ceil(WIDTH/STAGES) bits; the last chunk may be short or empty.
  - Stage k resolves chunk k using the resolved LSB of chunk k-1 as carry-in (carry-in 0 for chunk 0).
  - Unresolved Gray bits are carried forward unchanged with the beat.
- busy_o = OR of all stage valid bits.
- Reset mid-operation discards every in-flight beat. out_valid_o=0 the cycle after the reset edge, regardless of out_ready_i.
- in_valid_i high with in_ready_o=0: no accept. Upstream must hold data and mode (not checked).
- Simultaneous accept and emit on a full pipe with out_ready_i=1: both occur; occupancy is unchanged.
- WIDTH=1: both modes are identity. STAGES=WIDTH: one bit resolved per stage.

Test Plan:
- WIDTH=8, STAGES=2, mode0, in 8'hB4 -> 8'hEE, out_mode_o=0, 2 cycles after accept; then mode1, in 8'hEE -> 8'hB4.
- WIDTH=8, mode1, in 8'h80 -> 8'hFF; mode0, in 8'h80 -> 8'hC0; in 8'h00 in either mode -> 8'h00.
- Back-to-back interleaved stream 0x00..0xFF with alternating modes, out_ready_i held 1 -> 256 outputs in order, one per cycle, each matching the reference model.
- Random out_ready_i (50%) during a 1000-beat random stream -> no loss or duplication, out_data_o stable across every stalled cycle, busy_o=0 after drain.
- Pipe full with out_ready_i=0, rst_i pulsed 1 cycle -> next cycle out_valid_o=0, busy_o=0, out_data_o=0; the first post-reset beat converts correctly.
- Configuration sweep WIDTH in {1,5,32,64}, STAGES in {1,3,WIDTH} -> exhaustive (W<=8) or 10k random round-trips; gray2bin(bin2gray(x))==x, latency==STAGES.
